// File: rtl/ibex_pkg.sv
// Shared types and GF(2^8)/SHA-256 helpers for the scalar crypto (Zkn) unit.
// Functions are pure and synthesise to combinational logic.
package ibex_pkg;

    typedef enum logic [2:0] {
        ZKN_ESI,
        ZKN_ESMI,
        ZKN_DSI,
        ZKN_DSMI,
        ZKN_SIG0,
        ZKN_SIG1,
        ZKN_SUM0,
        ZKN_SUM1
    } zkn_op_e;

    typedef enum logic {
        ZKN_IDLE,
        ZKN_FINISH
    } zkn_state_e;

    function automatic logic zkn_is_aes(input zkn_op_e op);
        return (op == ZKN_ESI) || (op == ZKN_ESMI) || (op == ZKN_DSI) || (op == ZKN_DSMI);
    endfunction

    function automatic logic zkn_is_dec(input zkn_op_e op);
        return (op == ZKN_DSI) || (op == ZKN_DSMI);
    endfunction

    function automatic logic zkn_is_sha(input zkn_op_e op);
        return !zkn_is_aes(op);
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_affine(input logic [7:0] x);
        return x ^ rol8(x, 1) ^ rol8(x, 2) ^ rol8(x, 3) ^ rol8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_inv_affine(input logic [7:0] x);
        return rol8(x, 1) ^ rol8(x, 3) ^ rol8(x, 6) ^ 8'h05;
    endfunction

    // Column word before rotation; the DSMI arm is only built when decryption is enabled.
    function automatic logic [31:0] aes_word(input zkn_op_e op, input logic [7:0] s,
                                             input bit dec_en);
        logic [7:0] s2;
        logic [7:0] s4;
        logic [7:0] s8;
        s2 = gf_xtime(s);
        s4 = gf_xtime(s2);
        s8 = gf_xtime(s4);
        if (op == ZKN_ESMI) begin
            return {s2 ^ s, s, s, s2};
        end else if (dec_en && (op == ZKN_DSMI)) begin
            return {s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s, s8 ^ s4 ^ s2};
        end
        return {24'h0, s};
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sha_calc(input zkn_op_e op, input logic [31:0] a);
        case (op)
            ZKN_SIG0: return ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3);
            ZKN_SIG1: return ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
            ZKN_SUM0: return ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
            ZKN_SUM1: return ror32(a, 6) ^ ror32(a, 11) ^ ror32(a, 25);
            default:  return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/ibex_zkn_sbox.sv
// Combinational AES S-box / inverse S-box sharing one GF(2^8) inverter.
// Forward: affine(inv(x)); inverse: inv(inv_affine(x)).
module ibex_zkn_sbox
    import ibex_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    logic [7:0] w_pre;
    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30;
    logic [7:0] w_x60, w_x120, w_x240, w_x252, w_x254;

    assign w_pre = inv_i ? aes_inv_affine(data_i) : data_i;

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    assign w_x2   = gf_mul(w_pre, w_pre);
    assign w_x3   = gf_mul(w_x2, w_pre);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_x254 = gf_mul(w_x252, w_x2);

    assign data_o = inv_i ? w_x254 : aes_affine(w_x254);

endmodule

// File: rtl/ibex_zkn_unit.sv
// Scalar crypto unit: AES32 ES/ESM/DS/DSM and SHA-256 sigma/sum, with optional
// two-cycle AES and data-independent-timing mode via a small IDLE/FINISH FSM.
module ibex_zkn_unit
    import ibex_pkg::*;
#(
    parameter bit ZknDecrypt    = 1'b1,
    parameter bit ZknSha        = 1'b1,
    parameter bit ZknMultiCycle = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        sel_i,
    input  zkn_op_e     operator_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        ready_id_i,
    input  logic        data_ind_timing_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        illegal_o
);

    zkn_state_e  r_state, w_state_nxt;
    logic [7:0]  r_sbox;
    logic [1:0]  r_bs;
    zkn_op_e     r_op;
    logic [31:0] r_opa;  // operand_a for AES, finished result for SHA

    zkn_op_e     w_op;
    logic [31:0] w_a, w_b;
    logic        w_fin, w_multi, w_load, w_valid;
    logic [7:0]  w_byte, w_sbox_out, w_s;
    zkn_op_e     w_aes_op;
    logic [1:0]  w_aes_bs;
    logic [31:0] w_aes_a, w_word, w_rot, w_aes_res, w_sha_res, w_res;

    // Decoder select gates the data path only; en_i alone drives the FSM
    assign w_op = sel_i ? operator_i : ZKN_ESI;
    assign w_a  = sel_i ? operand_a_i : 32'h0;
    assign w_b  = sel_i ? operand_b_i : 32'h0;

    assign illegal_o = sel_i & ((!ZknDecrypt & zkn_is_dec(operator_i)) |
                                (!ZknSha & zkn_is_sha(operator_i)));

    assign w_multi = ZknMultiCycle & !illegal_o & (zkn_is_aes(w_op) | data_ind_timing_i);
    assign w_fin   = (r_state == ZKN_FINISH);

    always_comb begin
        w_byte = w_b[7:0];
        case (bs_i)
            2'd1:    w_byte = w_b[15:8];
            2'd2:    w_byte = w_b[23:16];
            2'd3:    w_byte = w_b[31:24];
            default: w_byte = w_b[7:0];
        endcase
    end

    ibex_zkn_sbox u_sbox (
        .data_i (w_byte),
        .inv_i  (ZknDecrypt & zkn_is_dec(w_op)),
        .data_o (w_sbox_out)
    );

    // In FINISH the AES tail runs purely from registered state
    assign w_s      = w_fin ? r_sbox : w_sbox_out;
    assign w_aes_op = w_fin ? r_op   : w_op;
    assign w_aes_bs = w_fin ? r_bs   : bs_i;
    assign w_aes_a  = w_fin ? r_opa  : w_a;

    assign w_word = aes_word(w_aes_op, w_s, ZknDecrypt);

    always_comb begin
        w_rot = w_word;
        case (w_aes_bs)
            2'd1:    w_rot = {w_word[23:0], w_word[31:24]};
            2'd2:    w_rot = {w_word[15:0], w_word[31:16]};
            2'd3:    w_rot = {w_word[7:0],  w_word[31:8]};
            default: w_rot = w_word;
        endcase
    end

    assign w_aes_res = w_aes_a ^ w_rot;
    assign w_sha_res = ZknSha ? sha_calc(w_op, w_a) : 32'h0;

    always_comb begin
        w_res = 32'h0;
        if (w_fin) begin
            w_res = zkn_is_aes(r_op) ? w_aes_res : r_opa;
        end else if (!illegal_o) begin
            w_res = zkn_is_aes(w_op) ? w_aes_res : w_sha_res;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ZKN_IDLE: begin
                if (en_i) begin
                    if (w_multi) begin
                        w_load      = 1'b1;
                        w_state_nxt = ZKN_FINISH;
                    end else begin
                        w_valid = 1'b1;
                    end
                end
            end
            ZKN_FINISH: begin
                if (!en_i) begin
                    w_state_nxt = ZKN_IDLE;
                end else begin
                    w_valid = 1'b1;
                    if (ready_id_i) w_state_nxt = ZKN_IDLE;
                end
            end
            default: w_state_nxt = ZKN_IDLE;
        endcase
    end

    // Reset masks valid combinationally so nothing escapes while rst_ni is low
    assign valid_o  = w_valid & rst_ni;
    assign result_o = valid_o ? w_res : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ZKN_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sbox <= 8'h0;
            r_bs   <= 2'd0;
            r_op   <= ZKN_ESI;
            r_opa  <= 32'h0;
        end else if (w_load) begin
            r_sbox <= w_sbox_out;
            r_bs   <= bs_i;
            r_op   <= w_op;
            r_opa  <= zkn_is_aes(w_op) ? w_a : w_sha_res;
        end
    end

endmodule

// File: tb/tb_ibex_zkn_unit.sv
// Self-checking bench: a default unit (A) and a ZknDecrypt=0/ZknMultiCycle=0 unit (B)
// share stimulus; expected results are queued per unit and popped on valid_o.
module tb_ibex_zkn_unit;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        sel_i = 1'b0;
    zkn_op_e     operator_i = ZKN_ESI;
    logic [1:0]  bs_i = 2'd0;
    logic [31:0] operand_a_i = 32'h0;
    logic [31:0] operand_b_i = 32'h0;
    logic        ready_id_i = 1'b1;
    logic        data_ind_timing_i = 1'b0;

    logic [31:0] result_a, result_b;
    logic        valid_a, valid_b, illegal_a, illegal_b;

    typedef struct {
        logic [31:0] res;
        int          lat;
        logic        ill;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    ibex_zkn_unit u_dut_a (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .sel_i             (sel_i),
        .operator_i        (operator_i),
        .bs_i              (bs_i),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .ready_id_i        (ready_id_i),
        .data_ind_timing_i (data_ind_timing_i),
        .result_o          (result_a),
        .valid_o           (valid_a),
        .illegal_o         (illegal_a)
    );

    ibex_zkn_unit #(
        .ZknDecrypt    (1'b0),
        .ZknSha        (1'b1),
        .ZknMultiCycle (1'b0)
    ) u_dut_b (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .sel_i             (sel_i),
        .operator_i        (operator_i),
        .bs_i              (bs_i),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .ready_id_i        (ready_id_i),
        .data_ind_timing_i (data_ind_timing_i),
        .result_o          (result_b),
        .valid_o           (valid_b),
        .illegal_o         (illegal_b)
    );

    // ---------------- reference model (FIPS-197 bitwise form, brute-force inverses)
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_ginv(input logic [7:0] x);
        if (x == 8'h0) return 8'h0;
        for (int y = 1; y < 256; y++) begin
            if (m_gmul(x, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h0;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] v;
        logic [7:0] c;
        logic [7:0] r;
        v = m_ginv(x);
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] m_inv_sbox(input logic [7:0] x);
        for (int y = 0; y < 256; y++) begin
            if (m_sbox(8'(y)) == x) return 8'(y);
        end
        return 8'h0;
    endfunction

    function automatic logic [31:0] m_rotr(input logic [31:0] a, input int n);
        logic [63:0] d;
        d = {a, a} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_model(input zkn_op_e op, input logic [1:0] bs,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  x;
        logic [7:0]  s;
        logic [31:0] w;
        x = 8'(b >> (8 * int'(bs)));
        case (op)
            ZKN_SIG0: return m_rotr(a, 7) ^ m_rotr(a, 18) ^ (a >> 3);
            ZKN_SIG1: return m_rotr(a, 17) ^ m_rotr(a, 19) ^ (a >> 10);
            ZKN_SUM0: return m_rotr(a, 2) ^ m_rotr(a, 13) ^ m_rotr(a, 22);
            ZKN_SUM1: return m_rotr(a, 6) ^ m_rotr(a, 11) ^ m_rotr(a, 25);
            default: ;
        endcase
        s = (op == ZKN_DSI || op == ZKN_DSMI) ? m_inv_sbox(x) : m_sbox(x);
        case (op)
            ZKN_ESMI: w = {m_gmul(s, 8'h03), s, s, m_gmul(s, 8'h02)};
            ZKN_DSMI: w = {m_gmul(s, 8'h0b), m_gmul(s, 8'h0d), m_gmul(s, 8'h09), m_gmul(s, 8'h0e)};
            default:  w = {24'h0, s};
        endcase
        return a ^ m_rotr(w, 32 - 8 * int'(bs));
    endfunction

    function automatic logic m_is_aes(input zkn_op_e op);
        return op == ZKN_ESI || op == ZKN_ESMI || op == ZKN_DSI || op == ZKN_DSMI;
    endfunction

    // ---------------- scoreboard driven operation
    task automatic do_op(input zkn_op_e op, input logic [1:0] bs, input logic [31:0] a,
                         input logic [31:0] b, input logic dit, input logic [31:0] exp,
                         input string name);
        exp_t e;
        logic dec;
        bit   got_a;
        bit   got_b;
        dec = (op == ZKN_DSI || op == ZKN_DSMI);
        q_a.push_back('{res: exp, lat: (m_is_aes(op) || dit) ? 2 : 1, ill: 1'b0});
        q_b.push_back('{res: dec ? 32'h0 : exp, lat: 1, ill: dec});
        @(posedge clk_i);
        #1;
        en_i = 1'b1; sel_i = 1'b1; operator_i = op; bs_i = bs;
        operand_a_i = a; operand_b_i = b; data_ind_timing_i = dit; ready_id_i = 1'b1;
        got_a = 1'b0;
        got_b = 1'b0;
        for (int c = 1; c <= 4 && !(got_a && got_b); c++) begin
            @(negedge clk_i);
            if (!got_a && valid_a) begin
                e = q_a.pop_front();
                got_a = 1'b1;
                n_vec++;
                if (result_a !== e.res || c != e.lat || illegal_a !== e.ill) begin
                    n_err++;
                    $display("FAIL %s unitA: got res=%h lat=%0d ill=%b want res=%h lat=%0d ill=%b",
                             name, result_a, c, illegal_a, e.res, e.lat, e.ill);
                end
            end
            if (!got_b && valid_b) begin
                e = q_b.pop_front();
                got_b = 1'b1;
                n_vec++;
                if (result_b !== e.res || c != e.lat || illegal_b !== e.ill) begin
                    n_err++;
                    $display("FAIL %s unitB: got res=%h lat=%0d ill=%b want res=%h lat=%0d ill=%b",
                             name, result_b, c, illegal_b, e.res, e.lat, e.ill);
                end
            end
        end
        if (!got_a) begin
            e = q_a.pop_front();
            n_vec++; n_err++;
            $display("FAIL %s unitA timeout: no valid_o, want res=%h", name, e.res);
        end
        if (!got_b) begin
            e = q_b.pop_front();
            n_vec++; n_err++;
            $display("FAIL %s unitB timeout: no valid_o, want res=%h", name, e.res);
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        en_i = 1'b1; sel_i = 1'b1; operator_i = ZKN_SIG0; operand_a_i = 32'h1;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b0 || result_a !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs_a: got valid=%b res=%h want valid=0 res=0",
                     valid_a, result_a);
        end
        n_vec++;
        if (valid_b !== 1'b0 || result_b !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs_b: got valid=%b res=%h want valid=0 res=0",
                     valid_b, result_b);
        end
        en_i = 1'b0; sel_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b0 || illegal_b !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_enable: got valid=%b ill=%b want valid=0 ill=0",
                     valid_a, illegal_b);
        end
    endtask

    task automatic test_spec_vectors();
        do_op(ZKN_ESI,  2'd0, 32'h0,        32'h0,  1'b0, 32'h00000063, "esi_zero");
        do_op(ZKN_ESMI, 2'd1, 32'h0,        32'h0,  1'b0, 32'h6363C6A5, "esmi_bs1");
        do_op(ZKN_ESMI, 2'd0, 32'h0,        32'h0,  1'b0, 32'hA56363C6, "esmi_bs0");
        do_op(ZKN_DSI,  2'd0, 32'hFFFFFFFF, 32'h0,  1'b0, 32'hFFFFFFAD, "dsi_ones");
        do_op(ZKN_DSMI, 2'd0, 32'h0,        32'h63, 1'b0, 32'h00000000, "dsmi_63");
        do_op(ZKN_SIG0, 2'd0, 32'h1,        32'h0,  1'b0, 32'h02004000, "sig0_dit0");
        do_op(ZKN_SUM0, 2'd0, 32'h1,        32'h0,  1'b0, 32'h40080400, "sum0_dit0");
        do_op(ZKN_SIG0, 2'd0, 32'h1,        32'h0,  1'b1, 32'h02004000, "sig0_dit1");
        do_op(ZKN_SUM0, 2'd0, 32'h1,        32'h0,  1'b1, 32'h40080400, "sum0_dit1");
    endtask

    task automatic test_random_ops();
        zkn_op_e     op;
        logic [1:0]  bs;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        for (int i = 0; i < 20; i++) begin
            op  = zkn_op_e'($urandom_range(0, 7));
            bs  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            dit = 1'($urandom_range(0, 1));
            do_op(op, bs, a, b, dit, m_model(op, bs, a, b), $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    task automatic test_ready_stall();
        logic [31:0] exp;
        logic [31:0] x;
        exp = m_model(ZKN_ESMI, 2'd2, 32'h1234_5678, 32'h00C3_0000);
        @(posedge clk_i);
        #1;
        en_i = 1'b1; sel_i = 1'b1; operator_i = ZKN_ESMI; bs_i = 2'd2;
        operand_a_i = 32'h1234_5678; operand_b_i = 32'h00C3_0000;
        data_ind_timing_i = 1'b0; ready_id_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL stall_first_cycle: got valid=%b want 0", valid_a);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 1) begin
                operator_i = ZKN_DSMI; bs_i = 2'd1;
                operand_a_i = $urandom; operand_b_i = $urandom;
            end
            if (k == 3) ready_id_i = 1'b1;
            @(negedge clk_i);
            n_vec++;
            if (valid_a !== 1'b1 || result_a !== exp) begin
                n_err++;
                $display("FAIL stall_hold%0d: got valid=%b res=%h want valid=1 res=%h",
                         k, valid_a, result_a, exp);
            end
        end
        x = $urandom;
        @(posedge clk_i);
        #1;
        operator_i = ZKN_SUM1; operand_a_i = x;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b1 || result_a !== m_model(ZKN_SUM1, 2'd0, x, 32'h0)) begin
            n_err++;
            $display("FAIL stall_back_to_idle: got valid=%b res=%h want valid=1 res=%h",
                     valid_a, result_a, m_model(ZKN_SUM1, 2'd0, x, 32'h0));
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] y;
        y = $urandom;
        @(posedge clk_i);
        #1;
        en_i = 1'b1; sel_i = 1'b1; operator_i = ZKN_DSMI; bs_i = 2'd3;
        operand_a_i = 32'hDEAD_BEEF; operand_b_i = 32'h5A00_0000;
        data_ind_timing_i = 1'b0; ready_id_i = 1'b0;
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL abort_valid_drop: got valid=%b want 0", valid_a);
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b1; operator_i = ZKN_SIG1; operand_a_i = y; ready_id_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b1 || result_a !== m_model(ZKN_SIG1, 2'd0, y, 32'h0)) begin
            n_err++;
            $display("FAIL abort_then_idle: got valid=%b res=%h want valid=1 res=%h",
                     valid_a, result_a, m_model(ZKN_SIG1, 2'd0, y, 32'h0));
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
    endtask

    task automatic test_reset_in_finish();
        @(posedge clk_i);
        #1;
        en_i = 1'b1; sel_i = 1'b1; operator_i = ZKN_ESI; bs_i = 2'd0;
        operand_a_i = 32'h0; operand_b_i = 32'h0; ready_id_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        n_vec++;
        if (valid_a !== 1'b1 || result_a !== 32'h63) begin
            n_err++;
            $display("FAIL rst_fin_reached: got valid=%b res=%h want valid=1 res=00000063",
                     valid_a, result_a);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if (valid_a !== 1'b0 || result_a !== 32'h0) begin
            n_err++;
            $display("FAIL rst_fin_immediate: got valid=%b res=%h want valid=0 res=0",
                     valid_a, result_a);
        end
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ready_id_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_vec++;
            if (valid_a !== 1'b0) begin
                n_err++;
                $display("FAIL rst_fin_quiet%0d: got valid=%b want 0", k, valid_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random_ops();
        test_ready_stall();
        test_abort();
        test_reset_in_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
